// File: rtl/room_read_pkg.sv
// Shared types for the collapse-cell read sequencer: response status codes,
// sequencer FSM states and the byte driven on rsp_data whenever status is not OK.
package room_read_pkg;

  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_MISS = 2'b01,
    ST_DEAD = 2'b10,
    ST_RSVD = 2'b11
  } rsp_status_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STROBE  = 3'd1,
    CONFIRM = 3'd2,
    RESP    = 3'd3,
    LOCKOUT = 3'd4
  } seq_state_e;

  localparam logic [7:0] SCRUB_BYTE = 8'h00;

endpackage

// File: rtl/room_sat_counter.sv
// Saturating event counter: +1 per cycle with inc high, sticks at all-ones.
// Single-cycle update, no backpressure; cleared only by synchronous reset.
module room_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/collapse_read_sequencer.sv
// Reader for one collapse cell: accept -> strobe (T+1) -> confirm (T+2) -> rsp (T+3), DEAD fast path at T+1;
// response held until rsp_ready, then LOCKOUT_CYCLES of req_ready=0. Audit counters under ROOM_READ_AUDIT_EN.
module collapse_read_sequencer
  import room_read_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = 4,
  parameter int AUDIT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_basis,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_status,
  output logic       cell_read,
  output logic [1:0] cell_read_basis,
  input  logic [7:0] cell_value_out,
  input  logic       cell_output_enable,
  input  logic       cell_fuse_fire,
  input  logic       cell_init,
  output logic       cell_live
`ifdef ROOM_READ_AUDIT_EN
  ,
  output logic [AUDIT_W-1:0] audit_reads,
  output logic [AUDIT_W-1:0] audit_hits,
  output logic [AUDIT_W-1:0] audit_misses,
  output logic [AUDIT_W-1:0] audit_dead
`endif
);

  localparam int LW = $clog2(LOCKOUT_CYCLES + 2);

  seq_state_e  state_q, state_d;
  logic [1:0]  basis_q, basis_d;
  logic [7:0]  cap_val_q, cap_val_d;
  logic        cap_oe_q, cap_oe_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  rsp_status_e rsp_status_q, rsp_status_d;
  logic        live_q, live_d;
  logic        pend_q, pend_d;
  logic        strobed_q, strobed_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic        rsp_hs;

  assign req_ready       = (state_q == IDLE) && !reset;
  assign rsp_valid       = (state_q == RESP);
  assign cell_read       = (state_q == STROBE);
  assign cell_read_basis = basis_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_status      = rsp_status_q;
  assign cell_live       = live_q;
  assign rsp_hs          = rsp_valid && rsp_ready;

  always_comb begin
    state_d      = state_q;
    basis_d      = basis_q;
    cap_val_d    = cap_val_q;
    cap_oe_d     = cap_oe_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    live_d       = live_q;
    pend_d       = pend_q;
    strobed_d    = strobed_q;
    lock_cnt_d   = lock_cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          basis_d = req_basis;
          if (live_q) begin
            state_d   = STROBE;
            strobed_d = 1'b1;
          end else begin
            state_d      = RESP;
            strobed_d    = 1'b0;
            rsp_status_d = ST_DEAD;
            rsp_data_d   = SCRUB_BYTE;
          end
        end
      end
      STROBE: begin
        cap_val_d = cell_value_out;
        cap_oe_d  = cell_output_enable;
        state_d   = CONFIRM;
      end
      CONFIRM: begin
        // A missing fuse pulse means the cell was already fused or killed.
        if (cell_fuse_fire && cap_oe_q) begin
          rsp_status_d = ST_OK;
          rsp_data_d   = cap_val_q;
        end else if (cell_fuse_fire) begin
          rsp_status_d = ST_MISS;
          rsp_data_d   = SCRUB_BYTE;
        end else begin
          rsp_status_d = ST_DEAD;
          rsp_data_d   = SCRUB_BYTE;
        end
        cap_val_d = SCRUB_BYTE;
        cap_oe_d  = 1'b0;
        state_d   = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_data_d   = SCRUB_BYTE;
          rsp_status_d = ST_OK;
          lock_cnt_d   = '0;
          state_d      = (strobed_q && (LOCKOUT_CYCLES > 0)) ? LOCKOUT : IDLE;
        end
      end
      LOCKOUT: begin
        if (lock_cnt_q == LW'(LOCKOUT_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (cell_init) begin
      if (state_q == IDLE) live_d = 1'b1;
      else                 pend_d = 1'b1;
    end
    if (cell_fuse_fire || (state_q == CONFIRM)) live_d = 1'b0;
    // Deferred re-arm lands on IDLE entry; CONFIRM never exits to IDLE, so its clear still wins.
    if ((state_d == IDLE) && (state_q != IDLE) && (pend_q || cell_init)) begin
      live_d = 1'b1;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      basis_q      <= 2'b00;
      cap_val_q    <= SCRUB_BYTE;
      cap_oe_q     <= 1'b0;
      rsp_data_q   <= SCRUB_BYTE;
      rsp_status_q <= ST_OK;
      live_q       <= 1'b0;
      pend_q       <= 1'b0;
      strobed_q    <= 1'b0;
      lock_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      basis_q      <= basis_d;
      cap_val_q    <= cap_val_d;
      cap_oe_q     <= cap_oe_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      live_q       <= live_d;
      pend_q       <= pend_d;
      strobed_q    <= strobed_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

`ifdef ROOM_READ_AUDIT_EN
  room_sat_counter #(.W(AUDIT_W)) u_cnt_reads (
    .clk(clk), .reset(reset), .inc(rsp_hs), .count(audit_reads));
  room_sat_counter #(.W(AUDIT_W)) u_cnt_hits (
    .clk(clk), .reset(reset), .inc(rsp_hs && (rsp_status_q == ST_OK)), .count(audit_hits));
  room_sat_counter #(.W(AUDIT_W)) u_cnt_misses (
    .clk(clk), .reset(reset), .inc(rsp_hs && (rsp_status_q == ST_MISS)), .count(audit_misses));
  room_sat_counter #(.W(AUDIT_W)) u_cnt_dead (
    .clk(clk), .reset(reset), .inc(rsp_hs && (rsp_status_q == ST_DEAD)), .count(audit_dead));
`endif

endmodule

// File: tb/tb_collapse_read_sequencer.sv
// Directed bench for collapse_read_sequencer with a small behavioural collapse cell.
module tb_collapse_read_sequencer;

`ifdef ROOM_READ_AUDIT_EN
  localparam int AW = 2;
`else
  localparam int AW = 16;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_basis = 2'b00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [1:0] rsp_status;
  logic       cell_read;
  logic [1:0] cell_read_basis;
  logic [7:0] cell_value_out;
  logic       cell_output_enable;
  logic       cell_fuse_fire;
  logic       cell_init = 1'b0;
  logic       cell_live;
`ifdef ROOM_READ_AUDIT_EN
  logic [AW-1:0] audit_reads, audit_hits, audit_misses, audit_dead;
`endif

  // Cell model: value/OE presented while strobed, fuse pulse one cycle later.
  logic [7:0] cfg_val  = 8'h00;
  logic       cfg_oe   = 1'b0;
  logic       cfg_fire = 1'b0;
  logic       fire_q   = 1'b0;
  int         strobe_cnt = 0;
  int         n_vec = 0;
  int         n_err = 0;

  assign cell_value_out     = cell_read ? cfg_val : 8'hEE;
  assign cell_output_enable = cell_read ? cfg_oe : 1'b0;
  assign cell_fuse_fire     = fire_q;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    fire_q <= cell_read && cfg_fire;
    if (cell_read) strobe_cnt <= strobe_cnt + 1;
  end

  collapse_read_sequencer #(.LOCKOUT_CYCLES(4), .AUDIT_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_basis(req_basis),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .cell_read(cell_read), .cell_read_basis(cell_read_basis),
    .cell_value_out(cell_value_out), .cell_output_enable(cell_output_enable),
    .cell_fuse_fire(cell_fuse_fire), .cell_init(cell_init), .cell_live(cell_live)
`ifdef ROOM_READ_AUDIT_EN
    , .audit_reads(audit_reads), .audit_hits(audit_hits),
    .audit_misses(audit_misses), .audit_dead(audit_dead)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_init();
    cell_init = 1'b1;
    tick();
    cell_init = 1'b0;
  endtask

  // Issue one request from IDLE and follow it through response and lockout.
  task automatic do_read(input logic [1:0] b, input bit strobe, input logic [1:0] st,
                         input logic [7:0] dat, input int hold, input bit init_in_resp);
    int s0;
    s0 = strobe_cnt;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_basis = b;
    tick();
    req_valid = 1'b0;
    if (strobe) begin
      chk("strobe_T1", 32'(cell_read), 32'd1);
      chk("strobe_basis", 32'(cell_read_basis), 32'(b));
      chk("no_rsp_T1", 32'(rsp_valid), 32'd0);
      tick();
      chk("strobe_one_cycle", 32'(cell_read), 32'd0);
      chk("no_rsp_T2", 32'(rsp_valid), 32'd0);
      tick();
    end else begin
      chk("dead_no_strobe", 32'(cell_read), 32'd0);
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_status", 32'(rsp_status), 32'(st));
    chk("rsp_data", 32'(rsp_data), 32'(dat));
    for (int i = 0; i < hold; i++) begin
      cell_init = init_in_resp && (i == 0);
      tick();
      cell_init = 1'b0;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'(dat));
      chk("hold_status", 32'(rsp_status), 32'(st));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_hs_valid", 32'(rsp_valid), 32'd0);
    chk("post_hs_data", 32'(rsp_data), 32'd0);
    chk("post_hs_status", 32'(rsp_status), 32'd0);
    chk("strobe_count", 32'(strobe_cnt - s0), strobe ? 32'd1 : 32'd0);
    if (strobe) begin
      req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        chk("lockout_rdy", 32'(req_ready), 32'd0);
        tick();
      end
      req_valid = 1'b0;
      chk("lockout_done", 32'(req_ready), 32'd1);
      chk("lockout_no_strobe", 32'(strobe_cnt - s0), 32'd1);
    end else begin
      chk("dead_no_lockout", 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_status", 32'(rsp_status), 32'd0);
    chk("rst_cell_read", 32'(cell_read), 32'd0);
    chk("rst_basis", 32'(cell_read_basis), 32'd0);
    chk("rst_live", 32'(cell_live), 32'd0);
    reset = 1'b0;
    tick();

    // OK read
    pulse_init();
    chk("live_after_init", 32'(cell_live), 32'd1);
    cfg_val = 8'h3C; cfg_oe = 1'b1; cfg_fire = 1'b1;
    do_read(2'd2, 1'b1, 2'b00, 8'h3C, 0, 1'b0);
    chk("live_after_ok", 32'(cell_live), 32'd0);

    // Wrong basis -> MISS, then DEAD fast path
    pulse_init();
    cfg_val = 8'h55; cfg_oe = 1'b0; cfg_fire = 1'b1;
    do_read(2'd1, 1'b1, 2'b01, 8'h00, 0, 1'b0);
    chk("live_after_miss", 32'(cell_live), 32'd0);
    do_read(2'd3, 1'b0, 2'b10, 8'h00, 0, 1'b0);

    // Fused cell: no fuse pulse
    pulse_init();
    cfg_val = 8'hAA; cfg_oe = 1'b1; cfg_fire = 1'b0;
    do_read(2'd0, 1'b1, 2'b10, 8'h00, 0, 1'b0);
    chk("live_after_fused", 32'(cell_live), 32'd0);

    // Re-arm during a stalled response
    pulse_init();
    cfg_val = 8'h5A; cfg_oe = 1'b1; cfg_fire = 1'b1;
    do_read(2'd1, 1'b1, 2'b00, 8'h5A, 5, 1'b1);
    chk("live_rearm_idle", 32'(cell_live), 32'd1);
    cfg_val = 8'hC3;
    do_read(2'd1, 1'b1, 2'b00, 8'hC3, 0, 1'b0);

    // Reset during STROBE
    pulse_init();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("pre_rst_strobe", 32'(cell_read), 32'd1);
    reset = 1'b1;
    tick();
    chk("midrst_cell_read", 32'(cell_read), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_live", 32'(cell_live), 32'd0);
    reset = 1'b0;
    tick();
    chk("midrst_idle", 32'(req_ready), 32'd1);
    chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);

`ifdef ROOM_READ_AUDIT_EN
    chk("audit_rst_reads", 32'(audit_reads), 32'd0);
    chk("audit_rst_hits", 32'(audit_hits), 32'd0);
    for (int k = 0; k < 4; k++) begin
      pulse_init();
      do_read(2'd0, 1'b1, 2'b00, 8'hC3, 0, 1'b0);
    end
    do_read(2'd0, 1'b0, 2'b10, 8'h00, 0, 1'b0);
    chk("audit_hits_sat", 32'(audit_hits), 32'd3);
    chk("audit_reads_sat", 32'(audit_reads), 32'd3);
    chk("audit_dead", 32'(audit_dead), 32'd1);
    chk("audit_misses", 32'(audit_misses), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
